// File: rtl/onehot6_encoder.sv
// onehot6_encoder
//   Purpose : encodes a 6-bit one-hot word into a 3-bit index. Illegal words
//             (all-zero, or multi-hot unless priority mode is enabled) are
//             flagged and counted. Results are queued in a 2-entry output FIFO.
//   Latency : 1 cycle from accept to FIFO head when the FIFO is empty.
//   Backpressure: in_ready drops only when the FIFO holds 2 entries. It is
//             decoded from registered occupancy, so there is no
//             combinational path from out_ready.
//   Config  : `ENC_PRIORITY_EN -- when defined, multi-hot words encode to the
//             index of their highest set bit with err=0.
//   Ports   : clk, rst_n (sync, active-low) | y_in/in_valid/in_ready (input
//             handshake) | code/err/out_valid/out_ready (output handshake) |
//             err_cnt (saturating count of accepted illegal words).

module onehot6_encoder #(
  parameter int DEPTH = 2,   // only 2 is supported
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       y_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       code,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt
);

  // Occupancy width follows DEPTH: 0..2 needs 2 bits.
  localparam int OCC_W = $clog2(DEPTH + 1);

  // The occupancy state value equals the entry count.
  typedef enum logic [OCC_W-1:0] {
    S_EMPTY = OCC_W'(0),
    S_ONE   = OCC_W'(1),
    S_FULL  = OCC_W'(2)
  } occ_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  occ_t             r_state;
  logic             r_wptr;
  logic             r_rptr;
  logic [3:0]       r_mem [2];    // {err, code} per entry
  logic [2:0]       r_code;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  // ---------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------
  logic [2:0]       w_ones;       // population count of y_in (0..6)
  logic [2:0]       w_hi_idx;     // index of highest set bit
  logic [2:0]       w_enc_code;
  logic             w_enc_err;
  logic             w_push;
  logic             w_pop;
  occ_t             w_state_nxt;
  logic             w_wptr_nxt;
  logic             w_rptr_nxt;
  logic [3:0]       w_mem_nxt [2];
  logic [3:0]       w_head_nxt;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_nxt;

  // ---------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------
  always_comb begin
    w_ones   = 3'd0;
    w_hi_idx = 3'd0;
    // Ascending scan: the last set bit seen is the highest one.
    for (int k = 0; k < 6; k++) begin
      if (y_in[k]) begin
        w_ones   = w_ones + 3'd1;
        w_hi_idx = 3'(k);
      end
    end
  end

  always_comb begin
    w_enc_code = 3'b111;
    w_enc_err  = 1'b1;
    if (w_ones == 3'd1) begin
      w_enc_code = w_hi_idx;
      w_enc_err  = 1'b0;
    end
`ifdef ENC_PRIORITY_EN
    else if (w_ones != 3'd0) begin
      // Multi-hot resolves to the highest set bit and is not an error.
      w_enc_code = w_hi_idx;
      w_enc_err  = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // ---------------------------------------------------------------------
  // Occupancy FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_push) w_state_nxt = S_ONE;
      end
      S_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = S_FULL;
        else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
        else                       w_state_nxt = S_ONE;
      end
      S_FULL: begin
        if (w_pop) w_state_nxt = S_ONE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pointers, storage and head
  // ---------------------------------------------------------------------
  // One-bit pointers wrap 1 -> 0 naturally.
  assign w_wptr_nxt = r_wptr ^ w_push;
  assign w_rptr_nxt = r_rptr ^ w_pop;

  always_comb begin
    w_mem_nxt[0] = r_mem[0];
    w_mem_nxt[1] = r_mem[1];
    if (w_push) w_mem_nxt[r_wptr] = {w_enc_err, w_enc_code};
  end

  // code/err are registered copies of the post-edge head. Deriving them from
  // next-state storage covers every case (push into empty, push+pop through a
  // single entry, pop from full) in one expression. When the FIFO goes empty
  // the previous head value is held.
  always_comb begin
    w_head_nxt = {r_err, r_code};
    if (w_state_nxt != S_EMPTY) w_head_nxt = w_mem_nxt[w_rptr_nxt];
  end

  // ---------------------------------------------------------------------
  // Error counter (saturating)
  // ---------------------------------------------------------------------
  assign w_cnt_sat = &r_err_cnt;

  always_comb begin
    w_cnt_nxt = r_err_cnt;
    if (w_push && w_enc_err && !w_cnt_sat) w_cnt_nxt = r_err_cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_mem[0]  <= 4'd0;
      r_mem[1]  <= 4'd0;
      r_code    <= 3'd0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_mem[0]  <= w_mem_nxt[0];
      r_mem[1]  <= w_mem_nxt[1];
      r_code    <= w_head_nxt[2:0];
      r_err     <= w_head_nxt[3];
      r_err_cnt <= w_cnt_nxt;
    end
  end

  assign code    = r_code;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_onehot6_encoder.sv
// Testbench for onehot6_encoder: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the encoder and FIFO.
module tb_onehot6_encoder;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [5:0]       y_in;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       code;
  logic             err;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] mq[$];     // queued {err, code}
  logic [3:0] m_head;    // value code/err should show (held when empty)
  int         m_cnt;

  onehot6_encoder #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code      (code),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoding rule from the word's value: a power of two maps to its log2.
  function automatic logic [3:0] ref_enc(input logic [5:0] y);
    int ones;
    int v;
    int idx;
    ones = $countones(y);
    v    = int'(y);
    idx  = -1;
    while (v != 0) begin
      v   = v / 2;
      idx = idx + 1;
    end
    if (ones == 1) return {1'b0, 3'(idx)};
`ifdef ENC_PRIORITY_EN
    if (ones > 1) return {1'b0, 3'(idx)};
`endif
    return 4'b1111;
  endfunction

  // Drive one cycle, advance the model across the edge, return at edge+1.
  task automatic step(input logic v, input logic [5:0] y, input logic ordy, input logic rst);
    logic       acc;
    logic       pop;
    logic [3:0] e;
    in_valid  = v;
    y_in      = y;
    out_ready = ordy;
    rst_n     = rst;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_cnt  = 0;
      m_head = 4'd0;
    end else begin
      acc = v && (mq.size() < 2);
      pop = ordy && (mq.size() > 0);
      e   = ref_enc(y);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        if (e[3] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      if (mq.size() > 0) m_head = mq[0];
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 6'b000001, 1'b0, 1'b0);
    step(1'b1, 6'b000010, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if ({err, code} !== 4'b0000) begin n_fail++; $display("FAIL reset_code_err: got %b%b want 0000", err, code); end
    n_checks++;
    if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    // Release with no traffic: nothing must have been enqueued during reset.
    step(1'b0, 6'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nothing_queued: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sweep();
    logic [5:0] w;
    for (int i = 0; i < 6; i++) begin
      w = 6'(1 << i);
      step(1'b1, w, 1'b1, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || code !== 3'(i) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_%0d: got v=%b code=%0d err=%b want v=1 code=%0d err=0", i, out_valid, code, err, i);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready_%0d: got %b want 1", i, in_ready); end
    end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || code !== 3'd5) begin
      n_fail++; $display("FAIL sweep_drain: got v=%b code=%0d want v=0 code=5 (held)", out_valid, code);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 6'b000100, 1'b0, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || code !== 3'd2) begin
      n_fail++; $display("FAIL bp_first: got rdy=%b v=%b code=%0d want rdy=1 v=1 code=2", in_ready, out_valid, code);
    end
    step(1'b1, 6'b010000, 1'b0, 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    step(1'b1, 6'b000001, 1'b0, 1'b1);
    n_checks++;
    if (in_ready !== 1'b0 || code !== 3'd2) begin
      n_fail++; $display("FAIL bp_hold: got rdy=%b code=%0d want rdy=0 code=2", in_ready, code);
    end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || code !== 3'd4 || err !== 1'b0) begin
      n_fail++; $display("FAIL bp_pop1: got rdy=%b v=%b code=%0d err=%b want rdy=1 v=1 code=4 err=0", in_ready, out_valid, code, err);
    end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pop2: out_valid got %b want 0 (third word must not be queued)", out_valid); end
  endtask

  task automatic test_illegal();
    logic [3:0] exp2;
    int         exp_cnt;
`ifdef ENC_PRIORITY_EN
    exp2    = 4'b0001;
    exp_cnt = 1;
`else
    exp2    = 4'b1111;
    exp_cnt = 2;
`endif
    step(1'b1, 6'b000000, 1'b0, 1'b1);
    step(1'b1, 6'b000011, 1'b0, 1'b1);
    n_checks++;
    if ({err, code} !== 4'b1111) begin n_fail++; $display("FAIL illegal_zero: got err=%b code=%0d want err=1 code=7", err, code); end
    n_checks++;
    if (err_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL illegal_cnt: got %0d want %0d", err_cnt, exp_cnt); end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if ({err, code} !== exp2) begin n_fail++; $display("FAIL illegal_multi: got err=%b code=%0d want %b", err, code, exp2); end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if (err_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL illegal_cnt_after_pop: got %0d want %0d", err_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    logic       v;
    logic [5:0] y;
    logic       ordy;
    logic       hold;
    hold = 1'b0;
    v    = 1'b0;
    y    = 6'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) y = 6'($urandom);
        else                           y = 6'(1 << $urandom_range(0, 5));
      end
      ordy = ($urandom_range(0, 2) != 0);
      // The producer must keep an unaccepted word stable.
      hold = v && (mq.size() >= 2);
      step(v, y, ordy, 1'b1);
      n_checks++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin
        n_fail++; $display("FAIL rand_flags_c%0d: got v=%b rdy=%b want occ=%0d", c, out_valid, in_ready, mq.size());
      end
      n_checks++;
      if ({err, code} !== m_head) begin
        n_fail++; $display("FAIL rand_head_c%0d: got %b%b want %b", c, err, code, m_head);
      end
      n_checks++;
      if (err_cnt !== CNT_W'(m_cnt)) begin
        n_fail++; $display("FAIL rand_cnt_c%0d: got %0d want %0d", c, err_cnt, m_cnt);
      end
    end
    while (mq.size() != 0) step(1'b0, 6'b0, 1'b1, 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 6'b000000, 1'b1, 1'b1);
      if (i == 100 || i == 299) begin
        n_checks++;
        if (err_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL sat_model_%0d: got %0d want %0d", i, err_cnt, m_cnt); end
      end
    end
    n_checks++;
    if (err_cnt !== CNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL sat_stop: got %0d want %0d", err_cnt, CNT_MAX); end
    step(1'b0, 6'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 6'b000010, 1'b0, 1'b1);
    step(1'b1, 6'b100000, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    step(1'b1, 6'b001000, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {err, code} !== 4'b0000 || err_cnt !== '0) begin
      n_fail++; $display("FAIL rmid_reset: got v=%b rdy=%b err=%b code=%0d cnt=%0d want 0 1 0 0 0", out_valid, in_ready, err, code, err_cnt);
    end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: out_valid got %b want 0", out_valid); end
    step(1'b1, 6'b001000, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || code !== 3'd3 || err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_fresh: got v=%b code=%0d err=%b want v=1 code=3 err=0", out_valid, code, err);
    end
    step(1'b0, 6'b0, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain: out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    y_in      = 6'b0;
    out_ready = 1'b0;
    m_head    = 4'd0;
    m_cnt     = 0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_illegal();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
